// File: rtl/pipe_stall_ctrl.sv
// Central stall controller for the 5-stage core: merges ID/EX/MEM stall requests and
// sequences multi-cycle EX ops. Optional perf counters are enabled by PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             flush,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_cycles,
    output logic             mc_done,
    output logic             mc_busy,
    output logic [5:0]       stall
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      mc_ops
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_eff;
    logic             start_ok;
    logic             ex_cond;

    always_comb begin
        start_ok = (state_q == IDLE) && mc_start && !flush;
        // A zero-length request still costs one stall cycle
        n_eff    = (mc_cycles == '0) ? CNT_W'(1) : mc_cycles;
        ex_cond  = stallreq_ex || start_ok || (state_q == RUN);

        stall = 6'b000000;
        if (!rst) begin
            if (stallreq_mem)     stall = 6'b011111;
            else if (ex_cond)     stall = 6'b001111;
            else if (stallreq_id) stall = 6'b000111;
        end

        mc_done = !rst && (state_q == DONE) && !flush;
        mc_busy = !rst && (state_q != IDLE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        cnt_d   = n_eff - CNT_W'(1);
                        state_d = (n_eff == CNT_W'(1)) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
                DONE: begin
                    // Hold the result handshake until EX/MEM is free to advance
                    if (!stall[3]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] mc_ops_q, mc_ops_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + (stall[0] ? 32'd1 : 32'd0);
        mc_ops_d       = mc_ops_q;
        if ((state_d == DONE) && (state_q != DONE)) mc_ops_d = mc_ops_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            mc_ops_q       <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            mc_ops_q       <= mc_ops_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mc_ops       = mc_ops_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model of the stall rules.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst, stallreq_id, stallreq_ex, stallreq_mem, flush, mc_start;
    logic [5:0] mc_cycles;
    logic       mc_done, mc_busy;
    logic [5:0] stall;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] mc_ops;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: remaining stall cycles of the op in flight, and a done flag
    int rem = 0;
    bit done_f = 1'b0;
    int m_stall_cyc = 0;
    int m_ops = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(6)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem), .flush(flush), .mc_start(mc_start),
        .mc_cycles(mc_cycles), .mc_done(mc_done), .mc_busy(mc_busy), .stall(stall)
`ifdef PIPE_STALL_PERF_EN
        , .stall_cycles(stall_cycles), .mc_ops(mc_ops)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit id, input bit ex, input bit mem,
                        input bit fl, input bit st, input int n);
        logic [5:0] e_stall;
        bit idle, seq, st3;
        int neff;
        @(negedge clk);
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        flush = fl; mc_start = st; mc_cycles = 6'(n);
        #1;
        if (r) begin
            chk("rst_stall", {26'd0, stall}, 32'd0);
            chk("rst_done", {31'd0, mc_done}, 32'd0);
            chk("rst_busy", {31'd0, mc_busy}, 32'd0);
`ifdef PIPE_STALL_PERF_EN
            chk("perf_stall_cyc", stall_cycles, 32'(m_stall_cyc));
            chk("perf_ops", {16'd0, mc_ops}, 32'(m_ops));
`endif
            rem = 0; done_f = 1'b0; m_stall_cyc = 0; m_ops = 0;
        end else begin
            idle = (rem == 0) && !done_f;
            seq  = (rem > 0) || (idle && st && !fl);
            st3  = mem || ex || seq;
            e_stall = mem ? 6'b011111 : st3 ? 6'b001111 : id ? 6'b000111 : 6'b000000;
            chk("stall", {26'd0, stall}, {26'd0, e_stall});
            chk("mc_done", {31'd0, mc_done}, {31'd0, done_f && !fl});
            chk("mc_busy", {31'd0, mc_busy}, {31'd0, (rem > 0) || done_f});
`ifdef PIPE_STALL_PERF_EN
            chk("perf_stall_cyc", stall_cycles, 32'(m_stall_cyc));
            chk("perf_ops", {16'd0, mc_ops}, 32'(m_ops));
`endif
            if (e_stall[0]) m_stall_cyc++;
            if (fl) begin
                rem = 0; done_f = 1'b0;
            end else if (idle && st) begin
                neff = (n == 0) ? 1 : n;
                rem = neff - 1;
                if (rem == 0) begin done_f = 1'b1; m_ops++; end
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) begin done_f = 1'b1; m_ops++; end
            end else if (done_f && !st3) begin
                done_f = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        flush = 1'b0; mc_start = 1'b0; mc_cycles = '0;

        // Reset with every request asserted
        step(1, 1, 1, 1, 1, 1, 5);
        step(1, 1, 1, 1, 1, 1, 5);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("tp_id_after_rst", {26'd0, stall}, 32'h07);

        // Priority ladder
        step(0, 1, 1, 1, 0, 0, 0); chk("tp_prio_mem", {26'd0, stall}, 32'h1F);
        step(0, 1, 1, 0, 0, 0, 0); chk("tp_prio_ex", {26'd0, stall}, 32'h0F);
        step(0, 1, 0, 0, 0, 0, 0); chk("tp_prio_id", {26'd0, stall}, 32'h07);

        // Four-cycle op, restart attempts while running must not disturb it
        step(0, 0, 0, 0, 0, 1, 4); chk("tp_mc4_start", {26'd0, stall}, 32'h0F);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 9);
            chk("tp_mc4_run", {26'd0, stall}, 32'h0F);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp_mc4_done", {31'd0, mc_done}, 32'd1);
        chk("tp_mc4_done_stall", {26'd0, stall}, 32'h00);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp_mc4_idle", {30'd0, mc_done, mc_busy}, 32'd0);

        // Zero and one-cycle ops
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0, 0, 1, k); chk("tp_short_start", {26'd0, stall}, 32'h0F);
            step(0, 0, 0, 0, 0, 0, 0); chk("tp_short_done", {31'd0, mc_done}, 32'd1);
            step(0, 0, 0, 0, 0, 0, 0); chk("tp_short_idle", {31'd0, mc_done}, 32'd0);
        end

        // Long op aborted by flush on its 10th RUN cycle
        step(0, 0, 0, 0, 0, 1, 32);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0); chk("tp_flush_cycle_done", {31'd0, mc_done}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp_flush_idle_stall", {26'd0, stall}, 32'h00);
        chk("tp_flush_idle_busy", {31'd0, mc_busy}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("tp_flush_no_done", {31'd0, mc_done}, 32'd0);
        end

        // Two-cycle op with MEM holding the DONE state
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            chk("tp_mem_hold_done", {31'd0, mc_done}, 32'd1);
            chk("tp_mem_hold_stall", {26'd0, stall}, 32'h1F);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp_mem_release_idle", {31'd0, mc_busy}, 32'd0);
`ifdef PIPE_STALL_PERF_EN
        chk("tp_perf_stall_cycles", stall_cycles, 32'd5);
        chk("tp_perf_mc_ops", {16'd0, mc_ops}, 32'd1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 200) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                 ($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 4) == 0,
                 (($urandom % 6) == 0) ? int'($urandom % 64) : int'($urandom % 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
